hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard and sequencing controller for the 16-bit five-stage CPU. It tracks the destination tags of in-flight instructions and drives the ALU operand forwarding selects used by the EX-stage ALU control. It also raises load-use and branch-operand stalls, flushes IF/ID on taken branches, and runs the HLT drain sequence. It sits beside the ID/EX pipeline registers and consumes decode signals from the ID stage.

## Interface
- REG_AW, 4, register address width (16 architectural registers; r0 reads as zero)
- HALT_DRAIN, 3, cycles needed to retire instructions behind HLT
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high, sampled on the rising edge of clk
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source registers of the ID instruction
- id_use_rs, id_use_rt  in  1  the ID instruction actually reads rs/rt
- id_rd  in  REG_AW  destination register
- id_regwrite, id_memread  in  1  writes the register file / is LW
- id_is_br, id_is_hlt  in  1  BR (register target, resolved in ID) / HLT
- br_taken  in  1  branch resolved taken in ID this cycle
- mem_busy  in  1  data memory not ready; freezes the whole pipeline
- ForwardA, ForwardB  out  2  EX operand select: 10 = MEM-stage ALU result, 01 = WB write data, 00 = register file
- ForwardBr  out  2  same encoding, for the BR register operand in ID
- stall_pc, stall_ifid  out  1  hold PC / hold IF/ID
- bubble_idex  out  1  load NOP into ID/EX
- flush_ifid  out  1  squash IF/ID
- halted  out  1  processor stopped

## Operation
- Tag pipeline: three stages, EX, MEM and WB. Each stage holds {valid, regwrite, memread, rd}; the EX stage also holds {use_rs, use_rt, rs, rt}. The pipeline advances every cycle unless mem_busy=1. On bubble_idex the EX stage loads valid=0.
- A tag matches only if it is valid, has regwrite=1, has rd≠0, and rd equals the source register.
- ForwardA uses EX.rs and ForwardB uses EX.rt. A MEM-stage match takes priority over a WB-stage match. Forwarding is gated by use_rs/use_rt. These outputs are combinational from registered tags.
- Load-use stall: asserted when EX.memread, EX has a matching rd, and the ID instruction uses that register. The stall sets stall_pc=stall_ifid=bubble_idex=1 for one cycle.
- Branch-operand stall (id_is_br): asserted when any EX-stage match exists on rs, or a MEM-stage memread match exists.
- Flush: flush_ifid = id_valid & br_taken & ~stall & ~mem_busy. A stalled branch's br_taken is ignored.
- mem_busy=1 forces stall_pc=stall_ifid=1, bubble_idex=0 and flush_ifid=0. It overrides every other request.
- Halt FSM states:
  - RUN: if an HLT is accepted in ID (id_valid, no stall, no mem_busy), go to DRAIN and set cnt=HALT_DRAIN.
  - DRAIN: stall_pc=1 and flush_ifid=1. cnt decrements on each non-busy cycle. When cnt reaches 1 and the pipeline advances, go to HALTED.
  - HALTED: halted=1, stall_pc=stall_ifid=1. The state is sticky until rst.
- Reset values: every tag valid=0, state RUN, cnt=0, all outputs 0.
- rst mid-DRAIN returns the FSM to RUN with halted=0.

## Timing
- Tags update on the rising edge. Forward, stall and flush outputs are valid in the same cycle their inputs are presented.
- Load-use costs exactly one bubble. The consumer then sees ForwardA/B=01, because the load is in WB by then.
- HLT accepted at cycle t with no mem_busy: halted=1 from cycle t+1+HALT_DRAIN. Each mem_busy cycle during DRAIN adds one cycle.
- Simultaneous load-use stall and HLT in ID: the stall wins, and HLT is re-evaluated next cycle.

## Configuration
- HAZARD_BR_FWD_EN defined: ForwardBr is active and selects the MEM/WB value for the BR register. A BR stalls only on the conditions listed under Operation.
- HAZARD_BR_FWD_EN undefined: ForwardBr is tied to 00. A BR stalls while any matching producer is in EX or MEM; the WB stage is covered by the register file's write-before-read.

## Structure
- hazard_pkg holds:
  - forwarding encodings FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - halt state encoding RUN/DRAIN/HALTED
  - the stage tag struct
- One sub-module, hazard_tag_stage: a single tag register with load, hold (mem_busy) and bubble controls. It is instantiated three times.

## Test plan
- ADD r1 then SUB r4,r1,r2 → in the SUB's EX cycle, ForwardA=10 and ForwardB=00.
- ADD r1, NOP, ADD r5,r3,r1 → ForwardB=01. With ADD r1 in both MEM and WB → ForwardB=10.
- LW r2 then ADD r3,r2,r2 → one cycle of stall_pc=stall_ifid=bubble_idex=1, then ForwardA=ForwardB=01. ADD r0 producer → all Forward outputs stay 00.
- BR on r6 right after ADD r6, with the macro defined → one stall cycle, then ForwardBr=10. Without the macro → two stall cycles and ForwardBr=00. A taken branch without a stall → flush_ifid=1 for one cycle.
- HLT accepted at t=10 → halted=1 at t=14. Repeat with mem_busy high for 2 cycles during DRAIN → halted=1 at t=16.
- rst asserted at the second DRAIN cycle → next cycle halted=0, state RUN, all Forward outputs 00, no stalls.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the five-stage pipeline hazard controller: forwarding
// encodings, halt FSM states, destination-tag structs and tag-match helpers.
package hazard_pkg;

    localparam int REG_AW          = 4;
    localparam int HALT_DRAIN_DFLT = 3;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } halt_state_t;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic [REG_AW-1:0] rd;
    } tag_t;

    typedef struct packed {
        logic              use_rs;
        logic              use_rt;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } src_t;

    typedef struct packed {
        tag_t tag;
        src_t src;
    } ex_tag_t;

    // r0 is hard-wired zero, so a producer targeting it never matches.
    function automatic logic tag_match(input tag_t t, input logic [REG_AW-1:0] src,
                                       input logic need_load);
        return t.valid && t.regwrite && (t.rd != {REG_AW{1'b0}}) && (t.rd == src)
               && (t.memread || !need_load);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_AW-1:0] src,
                                           input tag_t mem_tag, input tag_t wb_tag);
        logic [1:0] sel;
        if (use_src && tag_match(mem_tag, src, 1'b0)) begin
            sel = FWD_MEM;
        end else if (use_src && tag_match(wb_tag, src, 1'b0)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-side and control-side signals of the hazard controller; the ID stage
// holds the master end, hazard_unit holds the slave end.
interface hazard_unit_if
    import hazard_pkg::*;
;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_is_br;
    logic              id_is_hlt;
    logic              br_taken;
    logic              mem_busy;

    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic [1:0]        ForwardBr;
    logic              stall_pc;
    logic              stall_ifid;
    logic              bubble_idex;
    logic              flush_ifid;
    logic              halted;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
               id_regwrite, id_memread, id_is_br, id_is_hlt, br_taken, mem_busy,
        input  ForwardA, ForwardB, ForwardBr, stall_pc, stall_ifid,
               bubble_idex, flush_ifid, halted
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
               id_regwrite, id_memread, id_is_br, id_is_hlt, br_taken, mem_busy,
        output ForwardA, ForwardB, ForwardBr, stall_pc, stall_ifid,
               bubble_idex, flush_ifid, halted
    );

endinterface

// File: rtl/hazard_tag_stage.sv
// One pipeline stage of destination tags: loads each cycle, holds while the
// pipeline is frozen, and clears to an empty slot on a bubble.
module hazard_tag_stage
    import hazard_pkg::*;
#(
    parameter type T = tag_t
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic bubble,
    input  T     din,
    output T     q
);
    localparam int W = $bits(T);

    T q_r;

    // Tag register: hold has priority over bubble so a frozen pipeline keeps its tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= T'({W{1'b0}});
        end else if (hold) begin
            q_r <= q_r;
        end else if (bubble) begin
            q_r <= T'({W{1'b0}});
        end else begin
            q_r <= din;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: EX/MEM/WB tag tracking, operand forwarding,
// load-use and branch stalls, taken-branch flush and the HLT drain FSM.
// Optional build macro HAZARD_BR_FWD_EN enables forwarding to the ID-stage branch operand.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int HALT_DRAIN = HALT_DRAIN_DFLT
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);
    localparam int CNT_W = $clog2(HALT_DRAIN + 1);

    ex_tag_t          ex_din_s;
    ex_tag_t          ex_tag_r;
    tag_t             mem_tag_r;
    tag_t             wb_tag_r;

    logic             load_use_s;
    logic             br_hz_s;
    logic             stall_s;
    logic             hlt_accept_s;
    logic [1:0]       fwd_br_s;
    logic             stall_pc_s;
    logic             stall_ifid_s;
    logic             bubble_idex_s;
    logic             flush_ifid_s;
    logic             halted_s;

    halt_state_t      state_r;
    halt_state_t      state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Pack the ID instruction into the EX-stage tag.
    always_comb begin
        ex_din_s.tag.valid    = hz.id_valid;
        ex_din_s.tag.regwrite = hz.id_regwrite;
        ex_din_s.tag.memread  = hz.id_memread;
        ex_din_s.tag.rd       = hz.id_rd;
        ex_din_s.src.use_rs   = hz.id_use_rs;
        ex_din_s.src.use_rt   = hz.id_use_rt;
        ex_din_s.src.rs       = hz.id_rs;
        ex_din_s.src.rt       = hz.id_rt;
    end

    hazard_tag_stage #(.T(ex_tag_t)) u_ex_stage (
        .clk    (clk),
        .rst    (rst),
        .hold   (hz.mem_busy),
        .bubble (bubble_idex_s),
        .din    (ex_din_s),
        .q      (ex_tag_r)
    );

    hazard_tag_stage #(.T(tag_t)) u_mem_stage (
        .clk    (clk),
        .rst    (rst),
        .hold   (hz.mem_busy),
        .bubble (1'b0),
        .din    (ex_tag_r.tag),
        .q      (mem_tag_r)
    );

    hazard_tag_stage #(.T(tag_t)) u_wb_stage (
        .clk    (clk),
        .rst    (rst),
        .hold   (hz.mem_busy),
        .bubble (1'b0),
        .din    (mem_tag_r),
        .q      (wb_tag_r)
    );

    // Stall requests from a load in EX and from unresolved branch operands.
    always_comb begin
        load_use_s = hz.id_valid &&
                     ((hz.id_use_rs && tag_match(ex_tag_r.tag, hz.id_rs, 1'b1)) ||
                      (hz.id_use_rt && tag_match(ex_tag_r.tag, hz.id_rt, 1'b1)));
`ifdef HAZARD_BR_FWD_EN
        // ALU results in MEM can be forwarded; only loads there must wait.
        br_hz_s  = tag_match(ex_tag_r.tag, hz.id_rs, 1'b0) ||
                   tag_match(mem_tag_r, hz.id_rs, 1'b1);
        fwd_br_s = fwd_sel(1'b1, hz.id_rs, mem_tag_r, wb_tag_r);
`else
        // No branch bypass: wait until the producer reaches WB (write-before-read).
        br_hz_s  = tag_match(ex_tag_r.tag, hz.id_rs, 1'b0) ||
                   tag_match(mem_tag_r, hz.id_rs, 1'b0);
        fwd_br_s = FWD_REG;
`endif
        stall_s      = load_use_s || (hz.id_valid && hz.id_is_br && br_hz_s);
        hlt_accept_s = (state_r == RUN) && hz.id_valid && hz.id_is_hlt &&
                       !stall_s && !hz.mem_busy;
    end

    // Pipeline control: mem_busy freezes everything, halt states add their own holds.
    always_comb begin
        stall_pc_s    = 1'b0;
        stall_ifid_s  = 1'b0;
        bubble_idex_s = 1'b0;
        flush_ifid_s  = 1'b0;
        halted_s      = 1'b0;
        if (hz.mem_busy) begin
            stall_pc_s   = 1'b1;
            stall_ifid_s = 1'b1;
        end else begin
            stall_pc_s    = stall_s;
            stall_ifid_s  = stall_s;
            bubble_idex_s = stall_s;
            flush_ifid_s  = hz.id_valid && hz.br_taken && !stall_s;
        end
        case (state_r)
            DRAIN: begin
                stall_pc_s   = 1'b1;
                flush_ifid_s = !hz.mem_busy;
            end
            HALTED: begin
                stall_pc_s   = 1'b1;
                stall_ifid_s = 1'b1;
                halted_s     = 1'b1;
            end
            default: begin
                halted_s = 1'b0;
            end
        endcase
    end

    // Halt FSM next state: drain counts only cycles in which the pipeline advances.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            RUN: begin
                if (hlt_accept_s) begin
                    state_nxt_s = DRAIN;
                    cnt_nxt_s   = CNT_W'(HALT_DRAIN);
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (hz.mem_busy) begin
                    state_nxt_s = DRAIN;
                end else if (cnt_r == CNT_W'(1'b1)) begin
                    state_nxt_s = HALTED;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_W'(1'b1);
                end
            end
            HALTED: begin
                state_nxt_s = HALTED;
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Halt FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign hz.ForwardA    = fwd_sel(ex_tag_r.src.use_rs, ex_tag_r.src.rs, mem_tag_r, wb_tag_r);
    assign hz.ForwardB    = fwd_sel(ex_tag_r.src.use_rt, ex_tag_r.src.rt, mem_tag_r, wb_tag_r);
    assign hz.ForwardBr   = fwd_br_s;
    assign hz.stall_pc    = stall_pc_s;
    assign hz.stall_ifid  = stall_ifid_s;
    assign hz.bubble_idex = bubble_idex_s;
    assign hz.flush_ifid  = flush_ifid_s;
    assign hz.halted      = halted_s;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver queues hand-computed expectations
// each cycle, a negedge monitor pops and compares them against the outputs.
module tb_hazard_unit;

    logic clk = 1'b0;
    logic rst;

    hazard_unit_if hz ();

    hazard_unit #(.HALT_DRAIN(3)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] exp;
        logic [10:0] mask;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    exp_t        mon_e;
    string       mon_nm;
    logic [10:0] mon_act;

    localparam logic [10:0] M_FA  = 11'b11000000000;
    localparam logic [10:0] M_FB  = 11'b00110000000;
    localparam logic [10:0] M_FBR = 11'b00001100000;
    localparam logic [10:0] M_CTL = 11'b00000011110;
    localparam logic [10:0] M_HLT = 11'b00000000001;
    localparam logic [10:0] M_ALL = 11'b11111111111;

    // ctl = {stall_pc, stall_ifid, bubble_idex, flush_ifid}
    localparam logic [3:0] C0     = 4'b0000;
    localparam logic [3:0] CSTALL = 4'b1110;
    localparam logic [3:0] CFLUSH = 4'b0001;
    localparam logic [3:0] CBUSY  = 4'b1100;
    localparam logic [3:0] CDRAIN = 4'b1001;
    localparam logic [3:0] CHALT  = 4'b1100;

    function automatic logic [10:0] vec(input logic [1:0] fa, input logic [1:0] fb,
                                        input logic [1:0] fbr, input logic [3:0] ctl,
                                        input logic ht);
        return {fa, fb, fbr, ctl, ht};
    endfunction

    task automatic chk(input string nm, input logic [10:0] e, input logic [10:0] m);
        exp_t x;
        x.exp  = e;
        x.mask = m;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [3:0] rd, input logic [3:0] rs,
                             input logic [3:0] rt, input logic urs, input logic urt,
                             input logic rw, input logic mr, input logic br,
                             input logic hlt, input logic tk);
        hz.id_valid    = v;
        hz.id_rd       = rd;
        hz.id_rs       = rs;
        hz.id_rt       = rt;
        hz.id_use_rs   = urs;
        hz.id_use_rt   = urt;
        hz.id_regwrite = rw;
        hz.id_memread  = mr;
        hz.id_is_br    = br;
        hz.id_is_hlt   = hlt;
        hz.br_taken    = tk;
    endtask

    task automatic nop();
        set_instr(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic alu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
        set_instr(1'b1, rd, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [3:0] rd, input logic [3:0] rs);
        set_instr(1'b1, rd, rs, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic br_i(input logic [3:0] rs, input logic tk);
        set_instr(1'b1, 4'd0, rs, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, tk);
    endtask

    task automatic hlt_i();
        set_instr(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        nop();
        repeat (3) step();
    endtask

    task automatic do_reset();
        nop();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Monitor: one queued expectation belongs to the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                mon_e   = exp_q.pop_front();
                mon_nm  = name_q.pop_front();
                mon_act = {hz.ForwardA, hz.ForwardB, hz.ForwardBr, hz.stall_pc,
                           hz.stall_ifid, hz.bubble_idex, hz.flush_ifid, hz.halted};
                tests_run++;
                if (((mon_act ^ mon_e.exp) & mon_e.mask) != 11'd0) begin
                    tests_failed++;
                    $display("FAIL %s: got %b want %b (mask %b)", mon_nm,
                             mon_act & mon_e.mask, mon_e.exp & mon_e.mask, mon_e.mask);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        hz.mem_busy = 1'b0;
        nop();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset", vec(2'b00, 2'b00, 2'b00, C0, 1'b0), M_ALL);
        step();

        // ADD r1 ; SUB r4,r1,r2
        alu(4'd1, 4'd2, 4'd3); step();
        alu(4'd4, 4'd1, 4'd2);
        chk("sub_in_id_no_stall", vec(2'b00, 2'b00, 2'b00, C0, 1'b0), M_CTL);
        step();
        nop();
        chk("fwd_mem_a", vec(2'b10, 2'b00, 2'b00, C0, 1'b0), M_FA | M_FB);
        step();
        drain();

        // ADD r1 ; NOP ; ADD r5,r3,r1
        alu(4'd1, 4'd2, 4'd3); step();
        nop(); step();
        alu(4'd5, 4'd3, 4'd1); step();
        nop();
        chk("fwd_wb_b", vec(2'b00, 2'b01, 2'b00, C0, 1'b0), M_FA | M_FB);
        step();
        drain();

        // ADD r1 ; ADD r1 ; ADD r5,r3,r1 -> younger MEM producer wins
        alu(4'd1, 4'd2, 4'd3); step();
        alu(4'd1, 4'd2, 4'd3); step();
        alu(4'd5, 4'd3, 4'd1); step();
        nop();
        chk("fwd_mem_over_wb", vec(2'b00, 2'b10, 2'b00, C0, 1'b0), M_FA | M_FB);
        step();
        drain();

        // LW r2 ; ADD r3,r2,r2 -> one bubble then WB forwarding
        lw(4'd2, 4'd7); step();
        alu(4'd3, 4'd2, 4'd2);
        chk("lu_stall", vec(2'b00, 2'b00, 2'b00, CSTALL, 1'b0), M_CTL);
        step();
        chk("lu_release", vec(2'b00, 2'b00, 2'b00, C0, 1'b0), M_CTL);
        step();
        nop();
        chk("lu_fwd_wb", vec(2'b01, 2'b01, 2'b00, C0, 1'b0), M_FA | M_FB);
        step();
        drain();

        // Same load-use with mem_busy on the first cycle
        lw(4'd2, 4'd7); step();
        alu(4'd3, 4'd2, 4'd2);
        hz.mem_busy = 1'b1;
        chk("busy_override", vec(2'b00, 2'b00, 2'b00, CBUSY, 1'b0), M_CTL);
        step();
        hz.mem_busy = 1'b0;
        chk("busy_hold_stall", vec(2'b00, 2'b00, 2'b00, CSTALL, 1'b0), M_CTL);
        step();
        chk("busy_release", vec(2'b00, 2'b00, 2'b00, C0, 1'b0), M_CTL);
        step();
        nop();
        chk("busy_fwd_wb", vec(2'b01, 2'b01, 2'b00, C0, 1'b0), M_FA | M_FB);
        step();
        drain();

        // r0 producers never forward or stall
        alu(4'd0, 4'd1, 4'd2); step();
        alu(4'd4, 4'd0, 4'd0); step();
        br_i(4'd0, 1'b0);
        chk("r0_no_fwd", vec(2'b00, 2'b00, 2'b00, C0, 1'b0), M_FA | M_FB | M_FBR | M_CTL);
        step();
        drain();
        lw(4'd0, 4'd7); step();
        alu(4'd3, 4'd0, 4'd0);
        chk("r0_no_load_use", vec(2'b00, 2'b00, 2'b00, C0, 1'b0), M_CTL);
        step();
        drain();

        // ADD r6 ; BR r6 (taken)
        alu(4'd6, 4'd1, 4'd2); step();
        br_i(4'd6, 1'b1);
        chk("br_alu_stall1", vec(2'b00, 2'b00, 2'b00, CSTALL, 1'b0), M_CTL);
        step();
`ifdef HAZARD_BR_FWD_EN
        chk("br_alu_fwd_mem", vec(2'b00, 2'b00, 2'b10, CFLUSH, 1'b0), M_FBR | M_CTL);
        step();
`else
        chk("br_alu_stall2", vec(2'b00, 2'b00, 2'b00, CSTALL, 1'b0), M_FBR | M_CTL);
        step();
        chk("br_alu_go", vec(2'b00, 2'b00, 2'b00, CFLUSH, 1'b0), M_FBR | M_CTL);
        step();
`endif
        nop();
        chk("br_flush_once", vec(2'b00, 2'b00, 2'b00, C0, 1'b0), M_CTL);
        step();
        drain();

        // LW r6 ; BR r6 (taken) -> waits for WB in both builds
        lw(4'd6, 4'd7); step();
        br_i(4'd6, 1'b1);
        chk("br_lw_ex", vec(2'b00, 2'b00, 2'b00, CSTALL, 1'b0), M_CTL);
        step();
        chk("br_lw_mem", vec(2'b00, 2'b00, 2'b00, CSTALL, 1'b0), M_CTL);
        step();
`ifdef HAZARD_BR_FWD_EN
        chk("br_lw_wb", vec(2'b00, 2'b00, 2'b01, CFLUSH, 1'b0), M_FBR | M_CTL);
`else
        chk("br_lw_wb", vec(2'b00, 2'b00, 2'b00, CFLUSH, 1'b0), M_FBR | M_CTL);
`endif
        step();
        drain();

        // Taken branch with no hazard
        br_i(4'd9, 1'b1);
        chk("br_flush", vec(2'b00, 2'b00, 2'b00, CFLUSH, 1'b0), M_FBR | M_CTL);
        step();
        nop();
        chk("br_flush_end", vec(2'b00, 2'b00, 2'b00, C0, 1'b0), M_CTL);
        step();
        drain();

        // HLT: accepted at H, halted from H+4
        do_reset();
        hlt_i();
        chk("hlt_accept", vec(2'b00, 2'b00, 2'b00, C0, 1'b0), M_CTL | M_HLT);
        step();
        nop();
        for (int i = 0; i < 3; i++) begin
            chk("hlt_drain", vec(2'b00, 2'b00, 2'b00, CDRAIN, 1'b0), M_CTL | M_HLT);
            step();
        end
        chk("halted", vec(2'b00, 2'b00, 2'b00, CHALT, 1'b1), M_CTL | M_HLT);
        step();
        chk("halted_sticky", vec(2'b00, 2'b00, 2'b00, CHALT, 1'b1), M_CTL | M_HLT);
        step();

        // HLT with two mem_busy cycles in DRAIN: halted from H+6
        do_reset();
        hlt_i(); step();
        nop();
        chk("hb_drain1", vec(2'b00, 2'b00, 2'b00, CDRAIN, 1'b0), M_CTL | M_HLT);
        step();
        hz.mem_busy = 1'b1;
        chk("hb_busy1", vec(2'b00, 2'b00, 2'b00, CBUSY, 1'b0), M_CTL | M_HLT);
        step();
        chk("hb_busy2", vec(2'b00, 2'b00, 2'b00, CBUSY, 1'b0), M_CTL | M_HLT);
        step();
        hz.mem_busy = 1'b0;
        chk("hb_drain2", vec(2'b00, 2'b00, 2'b00, CDRAIN, 1'b0), M_CTL | M_HLT);
        step();
        chk("hb_drain3", vec(2'b00, 2'b00, 2'b00, CDRAIN, 1'b0), M_CTL | M_HLT);
        step();
        chk("hb_halted", vec(2'b00, 2'b00, 2'b00, CHALT, 1'b1), M_CTL | M_HLT);
        step();

        // rst on the second DRAIN cycle, with r1 forwarding pending
        do_reset();
        hlt_i(); step();
        alu(4'd1, 4'd2, 4'd3);
        chk("rd_drain1", vec(2'b00, 2'b00, 2'b00, CDRAIN, 1'b0), M_CTL | M_HLT);
        step();
        alu(4'd4, 4'd1, 4'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        nop();
        chk("rst_mid_drain", vec(2'b00, 2'b00, 2'b00, C0, 1'b0), M_ALL);
        step();
        hlt_i(); step();
        nop();
        chk("rst_run_again", vec(2'b00, 2'b00, 2'b00, CDRAIN, 1'b0), M_CTL | M_HLT);
        step();

        do_reset();
        step();
        step();
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
